lzx_194_seq_ctrl: RTL and testbench

- Upstream sequencer that drives one lzx_74HC194 universal shift register through its S[1:0], D[3:0], DSR and DSL pins.
- On START it loads a 4-bit pattern, paces a programmable number of right shifts, and optionally paces the same number of left shifts afterwards. This produces running-light and bounce sequences.
- It shares CLK and MR with the 194 it drives.
- It reads the 194's Q back through Q_FB. Q_FB is used only for the optional ring mode.

---
 rtl/lzx_seq_pkg.sv | 29 ++
 rtl/lzx_seq_pacer.sv | 34 +++
 rtl/lzx_194_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_lzx_194_seq_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lzx_seq_pkg.sv
// Shared definitions for the lzx_194 sequencer: state encoding, 194 mode
// constants, and the prescaler width helper.
package lzx_seq_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SHR  = 3'd2;
    localparam logic [2:0] ST_SHL  = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        SHR  = ST_SHR,
        SHL  = ST_SHL,
        FIN  = ST_FIN
    } seq_state_e;

    // 194 mode pins S[1:0]
    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_SHR  = 2'b01;
    localparam logic [1:0] S_SHL  = 2'b10;
    localparam logic [1:0] S_LOAD = 2'b11;

    function automatic int pacer_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/lzx_seq_pacer.sv
// Shift pacing prescaler: emits one tick every DIV running, unpaused clocks.
module lzx_seq_pacer
    import lzx_seq_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic CLK,
    input  logic MR,
    input  logic run,
    input  logic pause,
    input  logic clr,
    output logic tick
);

    localparam int PW = pacer_width(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pre;

    // The count wraps to zero on every tick, so a phase change on the last
    // tick already starts the next phase from a cleared prescaler.
    assign tick = run && !pause && (pre == LAST);

    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            pre <= '0;
        end else if (clr) begin
            pre <= '0;
        end else if (run && !pause) begin
            pre <= (pre == LAST) ? '0 : pre + PW'(1);
        end
    end

endmodule

// File: rtl/lzx_194_seq_ctrl.sv
// Sequencer driving an lzx_74HC194: load, paced right shifts, optional left bounce.
// Optional ring mode (DSR/DSL fed back from Q_FB) is enabled by LZX_SEQ_RING_EN.
module lzx_194_seq_ctrl
    import lzx_seq_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int DIV   = 4
) (
    input  logic             CLK,
    input  logic             MR,
    input  logic             START,
    input  logic             STOP,
    input  logic             PAUSE,
    input  logic             BOUNCE,
    input  logic             FILL,
    input  logic [3:0]       PATTERN,
    input  logic [CNT_W-1:0] STEPS,
    input  logic [3:0]       Q_FB,
    output logic [1:0]       S,
    output logic [3:0]       D,
    output logic             DSR,
    output logic             DSL,
    output logic             BUSY,
    output logic             DONE
);

    logic [2:0]       state;
    logic [CNT_W-1:0] steps_q;
    logic [CNT_W-1:0] step;
    logic             bounce_q;
    logic             shifting;
    logic             in_load;
    logic             tick;
    logic             last;

    assign shifting = (state == ST_SHR) || (state == ST_SHL);
    assign in_load  = (state == ST_LOAD);

    lzx_seq_pacer #(.DIV(DIV)) u_pacer (
        .CLK   (CLK),
        .MR    (MR),
        .run   (shifting),
        .pause (PAUSE),
        .clr   (in_load),
        .tick  (tick)
    );

    // steps_q is nonzero whenever a shift state is reached
    assign last = tick && ((step + CNT_W'(1)) == steps_q);

    // START is a request taken only in IDLE; DONE is a one-cycle pulse
    // decoded from the FIN state, never raised on a STOP abort.
    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            state    <= ST_IDLE;
            S        <= S_HOLD;
            D        <= '0;
            steps_q  <= '0;
            step     <= '0;
            bounce_q <= 1'b0;
        end else begin
            S <= S_HOLD;
            if (STOP) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (START) begin
                            steps_q  <= STEPS;
                            bounce_q <= BOUNCE;
                            D        <= PATTERN;
                            S        <= S_LOAD;
                            state    <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        step  <= '0;
                        state <= (steps_q != '0) ? ST_SHR : ST_FIN;
                    end
                    ST_SHR: begin
                        if (tick) begin
                            S    <= S_SHR;
                            step <= (last && bounce_q) ? '0 : step + CNT_W'(1);
                            if (last) state <= bounce_q ? ST_SHL : ST_FIN;
                        end
                    end
                    ST_SHL: begin
                        if (tick) begin
                            S    <= S_SHL;
                            step <= step + CNT_W'(1);
                            if (last) state <= ST_FIN;
                        end
                    end
                    ST_FIN:  state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign BUSY = (state != ST_IDLE);
    assign DONE = (state == ST_FIN);

`ifdef LZX_SEQ_RING_EN
    logic unused_fill;
    assign unused_fill = FILL;
    assign DSR = Q_FB[0];
    assign DSL = Q_FB[3];
`else
    logic unused_q_fb;
    assign unused_q_fb = ^Q_FB;
    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            DSR <= 1'b0;
            DSL <= 1'b0;
        end else begin
            DSR <= FILL;
            DSL <= FILL;
        end
    end
`endif

endmodule

// File: tb/tb_lzx_194_seq_ctrl.sv
// Bench for lzx_194_seq_ctrl with an attached behavioural 194 and a
// cycle-timing reference model derived from the pacing rules.
module tb_lzx_194_seq_ctrl;
    import lzx_seq_pkg::*;

    localparam int CNT_W  = 4;
    localparam int TB_DIV = 2;

    logic             CLK = 1'b0;
    logic             MR = 1'b0;
    logic             START = 1'b0;
    logic             STOP = 1'b0;
    logic             PAUSE = 1'b0;
    logic             BOUNCE = 1'b0;
    logic             FILL = 1'b0;
    logic [3:0]       PATTERN = '0;
    logic [CNT_W-1:0] STEPS = '0;
    logic [3:0]       q194;
    logic [1:0]       S;
    logic [3:0]       D;
    logic             DSR, DSL, BUSY, DONE;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] model_q = '0;

    lzx_194_seq_ctrl #(.CNT_W(CNT_W), .DIV(TB_DIV)) u_dut (
        .CLK(CLK), .MR(MR), .START(START), .STOP(STOP), .PAUSE(PAUSE),
        .BOUNCE(BOUNCE), .FILL(FILL), .PATTERN(PATTERN), .STEPS(STEPS),
        .Q_FB(q194), .S(S), .D(D), .DSR(DSR), .DSL(DSL), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // attached 74HC194: right shift moves toward Q[0], left toward Q[3]
    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) q194 <= '0;
        else begin
            case (S)
                S_SHR:   q194 <= {DSR, q194[3:1]};
                S_SHL:   q194 <= {q194[2:0], DSL};
                S_LOAD:  q194 <= D;
                default: q194 <= q194;
            endcase
        end
    end

    // Runs one sequence from IDLE; per edge the model predicts S/BUSY/DONE/D/Q
    // from pulse counting: one shift per TB_DIV unpaused shift-state edges.
    task automatic run_seq(input logic [3:0] pat, input int steps, input logic bnc,
                           input logic fil, input int pause_mode, input int stop_at,
                           input string tag);
        int n, pulses, act, e;
        logic [1:0] exp_s, prev_s;
        logic [3:0] eq;
        logic exp_busy, exp_done, exp_dsr, exp_dsl, cur_pause, cur_stop, fin;
        n = bnc ? 2 * steps : steps;
        pulses = 0; act = 0; e = 0; fin = 1'b0;
        prev_s = S_HOLD; eq = model_q;
        cur_pause = 1'b0; cur_stop = 1'b0;
        START = 1'b1; STOP = 1'b0; PAUSE = 1'b0;
        PATTERN = pat; STEPS = CNT_W'(steps); BOUNCE = bnc; FILL = fil;
        while (!fin) begin
            @(posedge CLK);
            @(negedge CLK);
`ifdef LZX_SEQ_RING_EN
            if (prev_s == S_SHR) eq = {eq[0], eq[3:1]};
            if (prev_s == S_SHL) eq = {eq[2:0], eq[3]};
`else
            if (prev_s == S_SHR) eq = {fil, eq[3:1]};
            if (prev_s == S_SHL) eq = {eq[2:0], fil};
`endif
            if (prev_s == S_LOAD) eq = pat;
            exp_s = S_HOLD; exp_busy = 1'b1; exp_done = 1'b0;
            if (cur_stop) begin
                exp_busy = 1'b0; fin = 1'b1;
            end else if (e == 0) begin
                exp_s = S_LOAD;
            end else if (e == 1) begin
                exp_done = (n == 0);
            end else if (pulses == n) begin
                exp_busy = 1'b0; fin = 1'b1;
            end else if (!cur_pause) begin
                act++;
                if (act % TB_DIV == 0) begin
                    pulses++;
                    exp_s = (pulses <= steps) ? S_SHR : S_SHL;
                    exp_done = (pulses == n);
                end
            end
`ifdef LZX_SEQ_RING_EN
            exp_dsr = eq[0]; exp_dsl = eq[3];
`else
            exp_dsr = fil; exp_dsl = fil;
`endif
            n_vec += 7;
            if (S !== exp_s) begin
                n_err++; $display("FAIL %s S e=%0d got=%b exp=%b", tag, e, S, exp_s);
            end
            if (BUSY !== exp_busy) begin
                n_err++; $display("FAIL %s BUSY e=%0d got=%b exp=%b", tag, e, BUSY, exp_busy);
            end
            if (DONE !== exp_done) begin
                n_err++; $display("FAIL %s DONE e=%0d got=%b exp=%b", tag, e, DONE, exp_done);
            end
            if (D !== pat) begin
                n_err++; $display("FAIL %s D e=%0d got=%b exp=%b", tag, e, D, pat);
            end
            if (q194 !== eq) begin
                n_err++; $display("FAIL %s Q e=%0d got=%b exp=%b", tag, e, q194, eq);
            end
            if (DSR !== exp_dsr) begin
                n_err++; $display("FAIL %s DSR e=%0d got=%b exp=%b", tag, e, DSR, exp_dsr);
            end
            if (DSL !== exp_dsl) begin
                n_err++; $display("FAIL %s DSL e=%0d got=%b exp=%b", tag, e, DSL, exp_dsl);
            end
            if (e > 400) begin
                n_vec++; n_err++;
                $display("FAIL %s timeout e=%0d got=busy exp=idle", tag, e);
                fin = 1'b1;
            end
            prev_s = exp_s;
            e++;
            case (pause_mode)
                1:       cur_pause = ($urandom_range(0, 2) == 0);
                2:       cur_pause = (e >= 4 && e < 9);
                default: cur_pause = 1'b0;
            endcase
            cur_stop = (e == stop_at);
            PAUSE = cur_pause;
            STOP = cur_stop;
            if (fin) START = 1'b0;
            else begin
                // START while busy, with changed inputs, must be ignored
                START = ($urandom_range(0, 3) == 0);
                if (START) begin
                    PATTERN = 4'($urandom);
                    STEPS = CNT_W'($urandom);
                    BOUNCE = 1'($urandom);
                end
            end
        end
        model_q = eq;
        START = 1'b0; PAUSE = 1'b0; STOP = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_vec += 6;
        if (S !== 2'b00) begin n_err++; $display("FAIL reset S got=%b exp=00", S); end
        if (D !== 4'b0000) begin n_err++; $display("FAIL reset D got=%b exp=0000", D); end
        if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset BUSY got=%b exp=0", BUSY); end
        if (DONE !== 1'b0) begin n_err++; $display("FAIL reset DONE got=%b exp=0", DONE); end
        if (DSR !== 1'b0) begin n_err++; $display("FAIL reset DSR got=%b exp=0", DSR); end
        if (DSL !== 1'b0) begin n_err++; $display("FAIL reset DSL got=%b exp=0", DSL); end
        @(negedge CLK);
        MR = 1'b1;
        model_q = '0;
        @(negedge CLK);
    endtask

    task automatic test_right_shift();
        run_seq(4'b1000, 3, 1'b0, 1'b0, 0, -1, "right");
    endtask

    task automatic test_bounce_fill();
        run_seq(4'b0000, 2, 1'b1, 1'b1, 0, -1, "bounce");
    endtask

    task automatic test_zero_steps();
        run_seq(4'b1011, 0, 1'b0, 1'b0, 0, -1, "zero");
    endtask

    task automatic test_pause();
        run_seq(4'b1100, 4, 1'b0, 1'b0, 2, -1, "pause");
    endtask

    task automatic test_stop();
        // pulses land on edges 3,5,7 (right) and 9,11,13 (left): abort mid-left
        run_seq(4'b1010, 3, 1'b1, 1'b0, 0, 10, "stop_shl");
        START = 1'b1; STOP = 1'b1; PATTERN = 4'b0110;
        @(posedge CLK);
        @(negedge CLK);
        n_vec += 3;
        if (S !== S_HOLD) begin n_err++; $display("FAIL stop_start S got=%b exp=00", S); end
        if (BUSY !== 1'b0) begin n_err++; $display("FAIL stop_start BUSY got=%b exp=0", BUSY); end
        if (D !== 4'b1010) begin n_err++; $display("FAIL stop_start D got=%b exp=1010", D); end
        START = 1'b0; STOP = 1'b0;
    endtask

    task automatic test_async_reset();
        START = 1'b1; PATTERN = 4'b1001; STEPS = CNT_W'(5); BOUNCE = 1'b0; FILL = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        #2 MR = 1'b0;
        #1;
        n_vec += 7;
        if (S !== 2'b00) begin n_err++; $display("FAIL arst S got=%b exp=00", S); end
        if (D !== 4'b0000) begin n_err++; $display("FAIL arst D got=%b exp=0000", D); end
        if (BUSY !== 1'b0) begin n_err++; $display("FAIL arst BUSY got=%b exp=0", BUSY); end
        if (DONE !== 1'b0) begin n_err++; $display("FAIL arst DONE got=%b exp=0", DONE); end
        if (DSR !== 1'b0) begin n_err++; $display("FAIL arst DSR got=%b exp=0", DSR); end
        if (DSL !== 1'b0) begin n_err++; $display("FAIL arst DSL got=%b exp=0", DSL); end
        if (q194 !== 4'b0000) begin n_err++; $display("FAIL arst Q got=%b exp=0000", q194); end
        @(negedge CLK);
        MR = 1'b1;
        model_q = '0;
        run_seq(4'b0110, 2, 1'b1, 1'b0, 0, -1, "post_rst");
    endtask

    task automatic test_ring();
        run_seq(4'b0001, 4, 1'b0, 1'b0, 0, -1, "ring");
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            run_seq(4'($urandom), $urandom_range(0, 5), 1'($urandom), 1'($urandom), 1,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(2, 20) : -1, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_right_shift();
        test_bounce_fill();
        test_zero_steps();
        test_pause();
        test_stop();
        test_async_reset();
        test_ring();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
